rn_apb_requester: RTL and testbench

Requester-node (RN) front end of the APB crossbar interconnect. Accepts single read/write commands from a local master and requests the shared path by raising `rn_valid` toward the completer-side arbitrator. Once granted through `cn_ready`, it runs one APB transfer with the SETUP and ACCESS phases, then releases the grant and returns a response. The address is decoded into the 3-bit one-hot `psel` that the arbitrator consumes as `icn_psel`.

---
 rtl/rn_apb_requester_if.sv | 39 +++
 rtl/rn_apb_requester.sv | 166 ++++++++++++++++
 tb/tb_rn_apb_requester.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/rn_apb_requester_if.sv
// Requester-node bundle: local command/response, arbitration
// request/grant, and the APB master bus.
interface rn_apb_requester_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rn_valid;
  logic              cn_ready;
  logic [2:0]        psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cn_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output rn_valid, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cn_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  rn_valid, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/rn_apb_requester.sv
// APB crossbar requester node: arbitrates for the shared path,
// runs one SETUP/ACCESS transfer, returns a response.
module rn_apb_requester #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst_n,
  rn_apb_requester_if.master bus
);

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, REQ, SETUP, ACCESS, RESP, RELEASE
  } state_e;

  state_e state_q, state_d;

  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        sel_q, sel_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              cmd_ready_q, cmd_ready_d;
  logic              rn_valid_q, rn_valid_d;
  logic [2:0]        psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [1:0]        region;
  logic              bus_on;

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    region      = bus.cmd_addr[ADDR_W-1 -: 2];

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          wr_d    = bus.cmd_write;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          unique case (1'b1)
            region == 2'b01: sel_d = 3'b001;
            region == 2'b10: sel_d = 3'b010;
            region == 2'b11: sel_d = 3'b100;
            default:         sel_d = 3'b000;
          endcase
          if (sel_d == 3'b000) begin
            state_d   = RESP;
            rsp_err_d = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus.cn_ready) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (bus.pready) begin
          state_d   = RESP;
          rsp_err_d = bus.pslverr;
          if (!wr_q && !bus.pslverr)
            rsp_rdata_d = bus.prdata;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (TIMEOUT > 0 && cnt_d == TO_V) begin
            state_d   = RESP;
            rsp_err_d = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        // a registered grant may linger; wait for it to drop
        if (!bus.cn_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    bus_on      = (state_d == SETUP) ||
                  (state_d == ACCESS);
    cmd_ready_d = (state_d == IDLE);
    rn_valid_d  = bus_on || (state_d == REQ);
    psel_d      = bus_on ? sel_d : 3'b000;
    penable_d   = (state_d == ACCESS);
    pwrite_d    = bus_on && wr_d;
    paddr_d     = bus_on ? addr_d : '0;
    pwdata_d    = bus_on ? wdata_d : '0;
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= 3'b000;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      rn_valid_q  <= 1'b0;
      psel_q      <= 3'b000;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rn_valid_q  <= rn_valid_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rn_valid  = rn_valid_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_rn_apb_requester.sv
// Bench for rn_apb_requester: directed and random commands,
// scoreboard on responses, phase counts and bus stability.
module tb_rn_apb_requester;

  localparam int TO = 4;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;

  exp_t exp_q[$];

  rn_apb_requester_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  rn_apb_requester #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h @cyc %0d",
               tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_spurious", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, bus.rsp_err},
            {31'd0, e.err});
        chk("rsp_cycle", cyc, e.at);
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) return;
    end
    chk("cmd_ready_wait", 32'd0, 32'd1);
  endtask

  // rw: idle ACCESS cycles before pready (-1 = never)
  // h: cycles cn_ready lingers after the response
  task automatic run_cmd(input bit wr,
                         input logic [31:0] addr,
                         input logic [31:0] wdata,
                         input logic [31:0] rdv,
                         input int gw, input int rw,
                         input bit se, input int h);
    exp_t e;
    logic [2:0] esel;
    int hs, n_acc, r, rel;
    int req_n, set_n, acc_n, bad;
    bit dec, to, got, granted, done;
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    hs = cyc;
    case (addr[31:30])
      2'b01:   esel = 3'b001;
      2'b10:   esel = 3'b010;
      2'b11:   esel = 3'b100;
      default: esel = 3'b000;
    endcase
    dec = (esel == 3'b000);
    to  = (rw < 0) || (rw >= TO);
    n_acc = dec ? 0 : (to ? TO : rw + 1);
    e.err   = dec || to || se;
    e.rdata = (e.err || wr) ? 32'd0 : rdv;
    e.at    = dec ? hs + 1 : hs + 3 + gw + n_acc;
    exp_q.push_back(e);
    r = 0; rel = 0; req_n = 0; set_n = 0;
    acc_n = 0; bad = 0;
    got = 0; granted = 0; done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (bus.psel != 3'b000) begin
        if (bus.penable) acc_n++;
        else set_n++;
        if (bus.psel !== esel || bus.paddr !== addr ||
            bus.pwrite !== wr || bus.pwdata !== wdata ||
            !bus.rn_valid)
          bad++;
      end
      if (got && bus.cmd_ready) begin
        done = 1;
        chk("release_len", cyc, r + 2 + h);
      end else if (bus.rsp_valid) begin
        got = 1; r = cyc; rel = 0;
        bus.cn_ready = granted && (h > 0);
      end else if (got) begin
        rel++;
        bus.cn_ready = granted && (rel <= h);
      end else if (bus.rn_valid && bus.psel == 3'b000) begin
        req_n++;
        if (req_n >= gw + 1) begin
          bus.cn_ready = 1'b1;
          granted = 1;
        end
      end
      bus.prdata  = rdv;
      bus.pready  = bus.penable && rw >= 0 &&
                    acc_n == rw + 1;
      bus.pslverr = se && bus.pready;
    end
    if (!done) chk("cmd_done_timeout", 32'd0, 32'd1);
    bus.cn_ready = 1'b0;
    bus.pready   = 1'b0;
    bus.pslverr  = 1'b0;
    if (dec) begin
      chk("dec_no_traffic", req_n + set_n + acc_n, 0);
    end else begin
      chk("req_cycles", req_n, gw + 1);
      chk("setup_cycles", set_n, 1);
      chk("access_cycles", acc_n, n_acc);
      chk("bus_stable", bad, 0);
    end
  endtask

  initial begin
    bit done;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cn_ready  = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_outs",
        {25'd0, bus.rn_valid, bus.psel, bus.penable,
         bus.pwrite, bus.rsp_valid, bus.rsp_err}, 32'd0);
    chk("rst_buses", bus.paddr | bus.pwdata |
        bus.rsp_rdata, 32'd0);
    rst_n = 1'b1;

    run_cmd(0, 32'h4000_0010, 32'h0, 32'hDEAD_BEEF,
            0, 0, 0, 0);
    run_cmd(1, 32'hC000_0004, 32'h1234_5678,
            32'hFFFF_FFFF, 4, 3, 0, 0);
    run_cmd(0, 32'h8000_0020, 32'h0, 32'hCAFE_F00D,
            0, 1, 1, 0);
    run_cmd(1, 32'h0000_0000, 32'h5555_AAAA,
            32'h0, 0, 0, 0, 0);
    run_cmd(0, 32'h4000_0080, 32'h0, 32'h1111_2222,
            1, -1, 0, 0);
    run_cmd(0, 32'h8000_0084, 32'h0, 32'h3333_4444,
            0, TO - 1, 0, 0);
    run_cmd(0, 32'h4000_0100, 32'h0, 32'h7777_8888,
            0, 0, 0, 3);

    // reset in the middle of ACCESS drops everything
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'hC000_0040;
    bus.cmd_wdata = 32'h0BAD_0BAD;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (bus.rn_valid) bus.cn_ready = 1'b1;
      if (bus.penable) done = 1;
    end
    chk("rst_reach_access", {31'd0, done}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_mid_outs",
        {26'd0, bus.rn_valid, bus.psel, bus.penable,
         bus.rsp_valid}, 32'd0);
    chk("rst_mid_paddr", bus.paddr, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ignores_grant",
          {30'd0, bus.rn_valid, bus.cmd_ready}, 32'd1);
    end
    bus.cn_ready = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      a = $urandom;
      a[31:30] = 2'($urandom_range(0, 3));
      run_cmd(1'($urandom_range(0, 1)), a, $urandom,
              $urandom, $urandom_range(0, 3),
              $urandom_range(0, 6) - 1,
              1'($urandom_range(0, 1)),
              $urandom_range(0, 2));
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
